// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-array memory target with programmable wait states and a one-cycle ready pulse
// Answers MemRead/MemWrite from the multicycle core; rejected requests respond with mem_error and no side effects.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  LAT     = 4'(LATENCY);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_rd;
  logic        r_wr;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_req;
  logic          w_rd;
  logic          w_wr;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_err;
  logic          w_commit;
  logic [AW-1:0] w_idx;

  assign w_req = mem_read | mem_write;

  // With LATENCY=0 the commit edge is also the accept edge, so the live inputs are used there.
  always_comb begin
    w_rd    = r_rd;
    w_wr    = r_wr;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      w_rd    = mem_read;
      w_wr    = mem_write;
      w_addr  = address;
      w_wdata = write_data;
    end
  end

  assign w_err = (w_rd & w_wr) | (|w_addr[1:0]) | (w_addr[31:2] >= DEPTH_W);
  assign w_idx = w_addr[AW+1:2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_rd    <= mem_read;
        r_wr    <= mem_write;
        r_addr  <= address;
        r_wdata <= write_data;
        r_cnt   <= LAT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err <= w_err;
        if (w_err) begin
          r_rdata <= 32'd0;
        end else if (w_rd) begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Array is not reset; the rst gate keeps a held request from writing while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && w_commit && !w_err && w_wr) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign mem_ready = (r_state == S_RESP);
  assign mem_error = mem_ready & r_err;
  assign read_data = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
// Instance 0 uses LATENCY=2, instance 1 LATENCY=0, instance 2 LATENCY=15; all DEPTH=256.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        s_rd    [3];
  logic        s_wr    [3];
  logic [31:0] s_addr  [3];
  logic [31:0] s_wdata [3];
  logic [31:0] o_rdata [3];
  logic        o_ready [3];
  logic        o_err   [3];

  int nvec;
  int nerr;

  mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .mem_read(s_rd[0]), .mem_write(s_wr[0]), .address(s_addr[0]), .write_data(s_wdata[0]),
    .read_data(o_rdata[0]), .mem_ready(o_ready[0]), .mem_error(o_err[0])
  );

  mem_responder #(.DEPTH(256), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst),
    .mem_read(s_rd[1]), .mem_write(s_wr[1]), .address(s_addr[1]), .write_data(s_wdata[1]),
    .read_data(o_rdata[1]), .mem_ready(o_ready[1]), .mem_error(o_err[1])
  );

  mem_responder #(.DEPTH(256), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst),
    .mem_read(s_rd[2]), .mem_write(s_wr[2]), .address(s_addr[2]), .write_data(s_wdata[2]),
    .read_data(o_rdata[2]), .mem_ready(o_ready[2]), .mem_error(o_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is presented for the following posedge.
  task automatic req(input int d, input string tag, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input int exp_n,
                     input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                     input logic chain);
    int n;
    s_rd[d]    = rd;
    s_wr[d]    = wr;
    s_addr[d]  = a;
    s_wdata[d] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready[d] && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    chk({tag, "_error"}, {31'd0, o_err[d]}, {31'd0, exp_err});
    if (chk_rd) chk({tag, "_rdata"}, o_rdata[d], exp_rd);
    if (!chain) begin
      s_rd[d] = 1'b0;
      s_wr[d] = 1'b0;
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, o_ready[d]}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_rd[i] = 1'b0; s_wr[i] = 1'b0; s_addr[i] = 32'd0; s_wdata[i] = 32'd0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, o_ready[0]}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, o_ready[0]}, 32'd0);
      chk("idle_error", {31'd0, o_err[0]}, 32'd0);
      chk("idle_rdata", o_rdata[0], 32'd0);
    end

    req(0, "wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 1'b1, 32'd0, 1'b0);
    req(0, "rd10", 1'b1, 1'b0, 32'h10, 32'd0, 3, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    req(0, "wr00", 1'b0, 1'b1, 32'h0, 32'h11111111, 3, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    req(0, "wr20", 1'b0, 1'b1, 32'h20, 32'h22222222, 3, 1'b0, 1'b0, 32'd0, 1'b0);
    req(0, "wr04", 1'b0, 1'b1, 32'h4, 32'h0BADF00D, 3, 1'b0, 1'b0, 32'd0, 1'b0);

    req(0, "rd12_misal", 1'b1, 1'b0, 32'h12, 32'd0, 3, 1'b1, 1'b1, 32'd0, 1'b0);
    req(0, "wr400_oor", 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 3, 1'b1, 1'b1, 32'd0, 1'b0);
    req(0, "rd00_after_oor", 1'b1, 1'b0, 32'h0, 32'd0, 3, 1'b0, 1'b1, 32'h11111111, 1'b0);
    req(0, "rdwr20_both", 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 3, 1'b1, 1'b1, 32'd0, 1'b0);
    req(0, "rd20_after_both", 1'b1, 1'b0, 32'h20, 32'd0, 3, 1'b0, 1'b1, 32'h22222222, 1'b0);

    req(0, "b2b_wr08", 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 3, 1'b0, 1'b1, 32'h22222222, 1'b1);
    req(0, "b2b_rd08", 1'b1, 1'b0, 32'h8, 32'd0, 4, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);

    s_wr[0] = 1'b1; s_addr[0] = 32'h4; s_wdata[0] = 32'h12345678;
    @(negedge clk);
    chk("abort_wait_ready", {31'd0, o_ready[0]}, 32'd0);
    rst = 1'b0;
    s_wr[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_ready", {31'd0, o_ready[0]}, 32'd0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_after_ready", {31'd0, o_ready[0]}, 32'd0);
    end
    req(0, "rd04_after_abort", 1'b1, 1'b0, 32'h4, 32'd0, 3, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);

    req(0, "wr04_resp_rst", 1'b0, 1'b1, 32'h4, 32'h12345678, 3, 1'b0, 1'b1, 32'h0BADF00D, 1'b1);
    rst = 1'b0;
    s_wr[0] = 1'b0;
    #1;
    chk("resp_rst_ready", {31'd0, o_ready[0]}, 32'd0);
    chk("resp_rst_error", {31'd0, o_err[0]}, 32'd0);
    chk("resp_rst_rdata", o_rdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req(0, "rd04_after_resp_rst", 1'b1, 1'b0, 32'h4, 32'd0, 3, 1'b0, 1'b1, 32'h12345678, 1'b0);

    req(1, "l0_wr00", 1'b0, 1'b1, 32'h0, 32'h5A5A0001, 1, 1'b0, 1'b1, 32'd0, 1'b0);
    req(1, "l0_rd00", 1'b1, 1'b0, 32'h0, 32'd0, 1, 1'b0, 1'b1, 32'h5A5A0001, 1'b0);
    req(2, "l15_wr00", 1'b0, 1'b1, 32'h0, 32'h5A5A000F, 16, 1'b0, 1'b1, 32'd0, 1'b0);
    req(2, "l15_rd00", 1'b1, 1'b0, 32'h0, 32'd0, 16, 1'b0, 1'b1, 32'h5A5A000F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
